lift_ctrl_locked_n: RTL and testbench

- Parametrised N-floor lift controller FSM with a registered request vector, SCAN (elevator) scheduling, and per-floor travel and door timers.
- Carries forward the team's key-locked state-duplication scheme. A key sampled at each departure selects either the functional move states or duplicated decoy move states.
- The decoy states give plausible outputs but wrong service.
- Serves as the next-generation lift benchmark for the locking-evaluation suite.

---
 rtl/lift_ctrl_locked_n.sv | 236 +++++++++++++++++++++++
 tb/tb_lift_ctrl_locked_n.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_ctrl_locked_n.sv
// N-floor lift controller: SCAN scheduling with registered requests and per-floor move/door timers.
// A key sampled on departure selects the real move states or decoy duplicates that drive to an end floor.
module lift_ctrl_locked_n #(
    parameter int                NUM_FLOORS  = 8,
    parameter int                FLOOR_W     = 3,
    parameter int                MOVE_CYCLES = 3,
    parameter int                DOOR_CYCLES = 4,
    parameter int                KEY_W       = 4,
    parameter logic [KEY_W-1:0]  CORRECT_KEY = 4'hA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [KEY_W-1:0]      key,
    input  logic                  door_obstruct,
    input  logic                  stop_btn,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  motor_up,
    output logic                  motor_dn,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] req_pending
);

    localparam int MV_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [MV_W-1:0]       MOVE_LOAD = MV_W'(MOVE_CYCLES - 1);
    localparam logic [DR_W-1:0]       DOOR_LOAD = DR_W'(DOOR_CYCLES - 1);
    localparam logic [MV_W-1:0]       MV_ONE    = MV_W'(1);
    localparam logic [DR_W-1:0]       DR_ONE    = DR_W'(1);
    localparam logic [FLOOR_W-1:0]    FL_ONE    = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    BOT_FLOOR = FLOOR_W'(0);
    localparam logic [NUM_FLOORS-1:0] OH_ONE    = NUM_FLOORS'(1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DN    = 3'd2;
    localparam logic [2:0] MOVE_UP_D  = 3'd3;
    localparam logic [2:0] MOVE_DN_D  = 3'd4;
    localparam logic [2:0] ARRIVE     = 3'd5;
    localparam logic [2:0] DOOR_OPEN  = 3'd6;
    localparam logic [2:0] DOOR_CLOSE = 3'd7;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            hit = hit | (r[i] & (i > int'(f)));
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            hit = hit | (r[i] & (i < int'(f)));
        end
        return hit;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] req_q, req_d;
    logic [MV_W-1:0]       move_tmr_q, move_tmr_d;
    logic [DR_W-1:0]       door_tmr_q, door_tmr_d;
    logic                  motor_up_q, motor_up_d;
    logic                  motor_dn_q, motor_dn_d;
    logic                  door_open_q, door_open_d;
    logic                  arrive_q, arrive_d;

    logic                  key_ok_s;
    logic [FLOOR_W-1:0]    floor_inc_s, floor_dec_s;
    logic [NUM_FLOORS-1:0] oh_here_s, oh_inc_s, oh_dec_s;

    assign key_ok_s    = (key == CORRECT_KEY);
    assign floor_inc_s = floor_q + FL_ONE;
    assign floor_dec_s = floor_q - FL_ONE;
    assign oh_here_s   = OH_ONE << floor_q;
    assign oh_inc_s    = OH_ONE << floor_inc_s;
    assign oh_dec_s    = OH_ONE << floor_dec_s;

    // Next-state, floor, direction, request and timer logic
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        req_d      = req_q | call_req;
        move_tmr_d = move_tmr_q;
        door_tmr_d = door_tmr_q;
        case (state_q)
            IDLE: begin
                if (|(req_q & oh_here_s)) begin
                    state_d = ARRIVE;
                end else if (dir_up_q && any_above(req_q, floor_q)) begin
                    state_d    = key_ok_s ? MOVE_UP : MOVE_UP_D;
                    move_tmr_d = MOVE_LOAD;
                end else if (dir_up_q && any_below(req_q, floor_q)) begin
                    state_d    = key_ok_s ? MOVE_DN : MOVE_DN_D;
                    move_tmr_d = MOVE_LOAD;
                    dir_up_d   = 1'b0;
                end else if (!dir_up_q && any_below(req_q, floor_q)) begin
                    state_d    = key_ok_s ? MOVE_DN : MOVE_DN_D;
                    move_tmr_d = MOVE_LOAD;
                end else if (!dir_up_q && any_above(req_q, floor_q)) begin
                    state_d    = key_ok_s ? MOVE_UP : MOVE_UP_D;
                    move_tmr_d = MOVE_LOAD;
                    dir_up_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_UP_D: begin
                if (stop_btn) begin
                    move_tmr_d = move_tmr_q;
                end else if (move_tmr_q != '0) begin
                    move_tmr_d = move_tmr_q - MV_ONE;
                end else if (floor_q == TOP_FLOOR) begin
                    state_d = IDLE;
                end else begin
                    floor_d = floor_inc_s;
                    // Decoy travel ignores requests and opens the door at the top floor
                    if (state_q == MOVE_UP_D) begin
                        if (floor_inc_s == TOP_FLOOR) begin
                            state_d    = DOOR_OPEN;
                            door_tmr_d = DOOR_LOAD;
                        end else begin
                            move_tmr_d = MOVE_LOAD;
                        end
                    end else if (|(req_q & oh_inc_s)) begin
                        state_d = ARRIVE;
                    end else if (any_above(req_q, floor_inc_s)) begin
                        move_tmr_d = MOVE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_DN, MOVE_DN_D: begin
                if (stop_btn) begin
                    move_tmr_d = move_tmr_q;
                end else if (move_tmr_q != '0) begin
                    move_tmr_d = move_tmr_q - MV_ONE;
                end else if (floor_q == BOT_FLOOR) begin
                    state_d = IDLE;
                end else begin
                    floor_d = floor_dec_s;
                    if (state_q == MOVE_DN_D) begin
                        if (floor_dec_s == BOT_FLOOR) begin
                            state_d    = DOOR_OPEN;
                            door_tmr_d = DOOR_LOAD;
                        end else begin
                            move_tmr_d = MOVE_LOAD;
                        end
                    end else if (|(req_q & oh_dec_s)) begin
                        state_d = ARRIVE;
                    end else if (any_below(req_q, floor_dec_s)) begin
                        move_tmr_d = MOVE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ARRIVE: begin
                req_d      = (req_q | call_req) & ~oh_here_s;
                door_tmr_d = DOOR_LOAD;
                state_d    = DOOR_OPEN;
            end
            DOOR_OPEN: begin
                // A call for this floor while open is absorbed; older pending bits are kept
                req_d = req_q | (call_req & ~oh_here_s);
                if (door_obstruct || (|(call_req & oh_here_s))) begin
                    door_tmr_d = DOOR_LOAD;
                end else if (door_tmr_q == '0) begin
                    state_d = DOOR_CLOSE;
                end else begin
                    door_tmr_d = door_tmr_q - DR_ONE;
                end
            end
            DOOR_CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs come straight from flops
    always_comb begin
        motor_up_d  = (state_d == MOVE_UP) || (state_d == MOVE_UP_D);
        motor_dn_d  = (state_d == MOVE_DN) || (state_d == MOVE_DN_D);
        door_open_d = (state_d == DOOR_OPEN);
        arrive_d    = (state_d == ARRIVE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            dir_up_q    <= 1'b1;
            req_q       <= '0;
            move_tmr_q  <= '0;
            door_tmr_q  <= '0;
            motor_up_q  <= 1'b0;
            motor_dn_q  <= 1'b0;
            door_open_q <= 1'b0;
            arrive_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            req_q       <= req_d;
            move_tmr_q  <= move_tmr_d;
            door_tmr_q  <= door_tmr_d;
            motor_up_q  <= motor_up_d;
            motor_dn_q  <= motor_dn_d;
            door_open_q <= door_open_d;
            arrive_q    <= arrive_d;
        end
    end

    assign floor       = floor_q;
    assign motor_up    = motor_up_q;
    assign motor_dn    = motor_dn_q;
    assign door_open   = door_open_q;
    assign dir_up      = dir_up_q;
    assign arrive      = arrive_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_lift_ctrl_locked_n.sv
// Directed bench for lift_ctrl_locked_n: a vector table for one correct-key trip plus
// hand-written sequences for obstruction, wrong key, SCAN ordering, stop and reset.
module tb_lift_ctrl_locked_n;

    logic       clk;
    logic       rst;
    logic [7:0] call_req;
    logic [3:0] key;
    logic       door_obstruct;
    logic       stop_btn;
    logic [2:0] floor;
    logic       motor_up;
    logic       motor_dn;
    logic       door_open;
    logic       dir_up;
    logic       arrive;
    logic [7:0] req_pending;

    int checks;
    int failures;

    lift_ctrl_locked_n dut (
        .clk          (clk),
        .rst          (rst),
        .call_req     (call_req),
        .key          (key),
        .door_obstruct(door_obstruct),
        .stop_btn     (stop_btn),
        .floor        (floor),
        .motor_up     (motor_up),
        .motor_dn     (motor_dn),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .arrive       (arrive),
        .req_pending  (req_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] call;
        logic [2:0] floor;
        logic       mu;
        logic       md;
        logic       dopen;
        logic       arr;
        logic       dir;
        logic [7:0] req;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [7:0] c, input logic [2:0] f, input logic mu, input logic md,
                                input logic dopen, input logic arr, input logic dir, input logic [7:0] r);
        vec_t v;
        v.call = c; v.floor = f; v.mu = mu; v.md = md; v.dopen = dopen; v.arr = arr; v.dir = dir; v.req = r;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        call_req = 8'h00;
        door_obstruct = 1'b0;
        stop_btn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_arrive(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!arrive && cyc < max_cyc);
        check("arrive_reached", 32'(arrive), 32'd1);
    endtask

    task automatic count_door(output int cnt, output int arr_seen);
        cnt = 0;
        arr_seen = 0;
        while (door_open && cnt < 40) begin
            tick();
            cnt++;
            if (arrive) arr_seen++;
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        int arr_seen;
        logic [15:0] got;
        logic [15:0] exp;

        checks = 0;
        failures = 0;
        key = 4'hA;

        // Correct-key trip 0 -> 3: one record per clock edge
        vecs[0]  = mk(8'h08, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[1]  = mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[2]  = mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[3]  = mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[4]  = mk(8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[5]  = mk(8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[6]  = mk(8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[7]  = mk(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[8]  = mk(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[9]  = mk(8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        vecs[10] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08);
        vecs[11] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        vecs[12] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        vecs[13] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        vecs[14] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        vecs[15] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        vecs[16] = mk(8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset state
        do_reset();
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_dir_up", 32'(dir_up), 32'd1);
        check("rst_req", 32'(req_pending), 32'h00);
        check("rst_outs", 32'({motor_up, motor_dn, door_open, arrive}), 32'h0);

        // Table-driven correct-key trip
        for (int i = 0; i < 17; i++) begin
            call_req = vecs[i].call;
            tick();
            got = {floor, motor_up, motor_dn, door_open, arrive, dir_up, req_pending};
            exp = {vecs[i].floor, vecs[i].mu, vecs[i].md, vecs[i].dopen, vecs[i].arr, vecs[i].dir, vecs[i].req};
            if (got !== exp) $display("  vector %0d differs", i);
            check($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end

        // Door obstruction at floor 3
        call_req = 8'h08;
        tick();
        call_req = 8'h00;
        tick();
        check("obs_arrive", 32'(arrive), 32'd1);
        tick();
        tick();
        door_obstruct = 1'b1;
        tick();
        tick();
        check("obs_held_open", 32'(door_open), 32'd1);
        door_obstruct = 1'b0;
        count_door(cnt, arr_seen);
        check("obs_door_cycles", 32'(cnt), 32'd4);
        check("obs_close_outs", 32'({motor_up, motor_dn, door_open, arrive}), 32'h0);
        check("obs_req", 32'(req_pending), 32'h00);

        // Wrong key: decoy runs to the top floor, no service
        do_reset();
        key = 4'h5;
        call_req = 8'h08;
        tick();
        call_req = 8'h00;
        tick();
        check("wk_motor_up", 32'(motor_up), 32'd1);
        cnt = 0;
        arr_seen = 0;
        while (motor_up && cnt < 100) begin
            tick();
            cnt++;
            if (arrive) arr_seen++;
        end
        check("wk_move_cycles", 32'(cnt), 32'd21);
        check("wk_floor", 32'(floor), 32'd7);
        check("wk_door_open", 32'(door_open), 32'd1);
        count_door(cnt, cyc);
        arr_seen += cyc;
        check("wk_door_cycles", 32'(cnt), 32'd4);
        check("wk_no_arrive", 32'(arr_seen), 32'd0);
        check("wk_req_kept", 32'(req_pending), 32'h08);
        check("wk_dir_up", 32'(dir_up), 32'd1);

        // SCAN: park at floor 2, then requests 5 and 1
        do_reset();
        key = 4'hA;
        call_req = 8'h04;
        tick();
        call_req = 8'h00;
        wait_arrive(50, cyc);
        check("scan_park_cycles", 32'(cyc), 32'd7);
        repeat (6) tick();
        check("scan_park_floor", 32'(floor), 32'd2);
        call_req = 8'h22;
        tick();
        call_req = 8'h00;
        wait_arrive(50, cyc);
        check("scan_up_cycles", 32'(cyc), 32'd10);
        check("scan_first_floor", 32'(floor), 32'd5);
        check("scan_req_at5", 32'(req_pending), 32'h22);
        repeat (6) tick();
        check("scan_req_after5", 32'(req_pending), 32'h02);
        check("scan_dir_before", 32'(dir_up), 32'd1);
        tick();
        check("scan_dir_down", 32'(dir_up), 32'd0);
        check("scan_motor", 32'({motor_up, motor_dn}), 32'h1);
        tick();
        stop_btn = 1'b1;
        repeat (5) tick();
        check("stop_hold", 32'({floor, motor_dn, door_open}), 32'({3'd5, 1'b1, 1'b0}));
        stop_btn = 1'b0;
        tick();
        check("stop_floor_7", 32'(floor), 32'd5);
        tick();
        check("stop_floor_8", 32'(floor), 32'd4);
        wait_arrive(50, cyc);
        check("scan_dn_cycles", 32'(cyc), 32'd9);
        check("scan_second_floor", 32'(floor), 32'd1);
        tick();
        check("scan_req_final", 32'(req_pending), 32'h00);

        // Call at current idle floor: ARRIVE without motor; repeat call while open is absorbed
        do_reset();
        call_req = 8'h01;
        tick();
        call_req = 8'h00;
        tick();
        check("here_arrive", 32'({arrive, motor_up, motor_dn, floor}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
        tick();
        check("here_open", 32'({door_open, req_pending}), 32'({1'b1, 8'h00}));
        tick();
        call_req = 8'h01;
        tick();
        call_req = 8'h00;
        check("here_recall_req", 32'(req_pending), 32'h00);
        count_door(cnt, arr_seen);
        check("here_door_cycles", 32'(cnt), 32'd4);
        check("here_no_rearrive", 32'(arr_seen), 32'd0);

        // Reset while moving up past floor 4
        do_reset();
        call_req = 8'h80;
        tick();
        call_req = 8'h00;
        cnt = 0;
        while (floor != 3'd4 && cnt < 50) begin
            tick();
            cnt++;
        end
        check("mv_reach4", 32'(floor), 32'd4);
        tick();
        check("mv_moving", 32'(motor_up), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mv_rst_state", 32'({floor, motor_up, motor_dn, door_open, dir_up, req_pending}),
              32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}));
        tick();
        check("mv_rst_idle", 32'({motor_up, motor_dn, arrive}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
